// File: rtl/rf_pkg.sv
// Shared defaults and port-slice helpers for the pending-scoreboard register file.
package rf_pkg;

    localparam int W_DEF     = 32;
    localparam int AW_DEF    = 5;
    localparam int NREAD_DEF = 2;

    // Lowest bit of port k inside a flattened multi-port bus whose fields are `width` bits wide.
    function automatic int port_lo(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/rf_pending_ctl.sv
// Per-register pending bits plus a registered population count.
// The count is kept consistent with the pending bits incrementally.
module rf_pending_ctl
    import rf_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en_i,
    input  logic [AW-1:0]     set_idx_i,
    input  logic              clr_en_i,
    input  logic [AW-1:0]     clr_idx_i,
    output logic [2**AW-1:0]  pend_o,
    output logic [AW:0]       cnt_o
);

    localparam int N = 2 ** AW;

    logic [N-1:0] pend_q, pend_d;
    logic [AW:0]  cnt_q,  cnt_d;
    logic         inc, dec, same_reg;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        pend_d   = pend_q;
        same_reg = set_en_i && (set_idx_i == clr_idx_i);
        inc      = set_en_i && !pend_q[set_idx_i];
        // A reserve of the register being written marks a newer producer, so nothing is released.
        dec      = clr_en_i && pend_q[clr_idx_i] && !same_reg;
        if (clr_en_i) pend_d[clr_idx_i] = 1'b0;
        if (set_en_i) pend_d[set_idx_i] = 1'b1;
        cnt_d = cnt_q + (AW+1)'(inc) - (AW+1)'(dec);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pend_o = pend_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/rf_scoreboard.sv
// Multi-read register file with optional hardwired R0, write-to-read bypass
// and a pending scoreboard for stalling readers until writeback.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int AW      = AW_DEF,
    parameter int NREAD   = NREAD_DEF,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREAD*AW-1:0] rn,
    output logic [NREAD*W-1:0]  rd,
    output logic [NREAD-1:0]    rd_ready,
    input  logic [AW-1:0]       wn,
    input  logic [W-1:0]        wd,
    input  logic                w,
    input  logic                res_en,
    input  logic [AW-1:0]       res_n,
    output logic [AW:0]         pend_cnt,
    output logic                any_pending
);

    localparam int N = 2 ** AW;

    logic [W-1:0] mem_q [N];
    logic [N-1:0] pend;
    logic         wr_en, rs_en;

    assign wr_en = w      && !(ZERO_R0 && (wn    == '0));
    assign rs_en = res_en && !(ZERO_R0 && (res_n == '0));

    // NOTE: the storage array is reset on purpose; a clear must return every register to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wn] <= wd;
        end
    end

    rf_pending_ctl #(.AW(AW)) u_pending (
        .clk       (clk),
        .reset     (reset),
        .set_en_i  (rs_en),
        .set_idx_i (res_n),
        .clr_en_i  (wr_en),
        .clr_idx_i (wn),
        .pend_o    (pend),
        .cnt_o     (pend_cnt)
    );

    assign any_pending = (pend_cnt != '0);

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0] addr;
        logic          is_r0, hit;

        assign addr  = rn[port_lo(k, AW) +: AW];
        assign is_r0 = ZERO_R0 && (addr == '0);
        assign hit   = BYPASS && wr_en && (wn == addr);

        // Reset forces the idle view even if a write is being presented during the clear.
        assign rd[port_lo(k, W) +: W] = (reset || is_r0) ? '0 :
                                        hit              ? wd : mem_q[addr];
        assign rd_ready[k] = reset || is_r0 || hit || !pend[addr];
    end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed self-checking bench: default configuration plus a narrow 4-port no-bypass instance.
module tb_rf_scoreboard;

    logic        clk;
    logic        reset;

    logic [9:0]  rn;
    logic [63:0] rd;
    logic [1:0]  rd_ready;
    logic [4:0]  wn;
    logic [31:0] wd;
    logic        w;
    logic        res_en;
    logic [4:0]  res_n;
    logic [5:0]  pend_cnt;
    logic        any_pending;

    logic [11:0] rn2;
    logic [63:0] rd2;
    logic [3:0]  rd_ready2;
    logic [2:0]  wn2;
    logic [15:0] wd2;
    logic        w2;
    logic        res_en2;
    logic [2:0]  res_n2;
    logic [3:0]  pend_cnt2;
    logic        any_pending2;

    int n_checks = 0;
    int n_errs   = 0;

    int pa [5] = '{0, 5, 17, 30, 31};
    int pb [5] = '{1, 31, 2, 0, 16};

    rf_scoreboard u_dut (
        .clk         (clk),
        .reset       (reset),
        .rn          (rn),
        .rd          (rd),
        .rd_ready    (rd_ready),
        .wn          (wn),
        .wd          (wd),
        .w           (w),
        .res_en      (res_en),
        .res_n       (res_n),
        .pend_cnt    (pend_cnt),
        .any_pending (any_pending)
    );

    rf_scoreboard #(
        .W       (16),
        .AW      (3),
        .NREAD   (4),
        .ZERO_R0 (1'b1),
        .BYPASS  (1'b0)
    ) u_dut2 (
        .clk         (clk),
        .reset       (reset),
        .rn          (rn2),
        .rd          (rd2),
        .rd_ready    (rd_ready2),
        .wn          (wn2),
        .wd          (wd2),
        .w           (w2),
        .res_en      (res_en2),
        .res_n       (res_n2),
        .pend_cnt    (pend_cnt2),
        .any_pending (any_pending2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        rn      = '0;
        wn      = '0;
        wd      = '0;
        w       = 1'b0;
        res_en  = 1'b0;
        res_n   = '0;
        rn2     = '0;
        wn2     = '0;
        wd2     = '0;
        w2      = 1'b0;
        res_en2 = 1'b0;
        res_n2  = '0;

        // Reset view, with a bypassable write presented to prove it is masked.
        #2;
        rn = {5'd3, 5'd3};
        wn = 5'd3;
        wd = 32'hDEAD_BEEF;
        w  = 1'b1;
        #1;
        check("reset_rd",       64'(rd),          64'h0);
        check("reset_ready",    64'(rd_ready),    64'h3);
        check("reset_cnt",      64'(pend_cnt),    64'h0);
        check("reset_any",      64'(any_pending), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        w     = 1'b0;

        // Fill r0..r31 with i*i; the r0 write must be discarded.
        tick();
        for (int i = 0; i < 32; i++) begin
            w  = 1'b1;
            wn = 5'(i);
            wd = 32'(i * i);
            tick();
        end
        w = 1'b0;

        for (int p = 0; p < 5; p++) begin
            rn = {5'(pb[p]), 5'(pa[p])};
            #1;
            check("fill_rd",    64'(rd),       {32'(pb[p] * pb[p]), 32'(pa[p] * pa[p])});
            check("fill_ready", 64'(rd_ready), 64'h3);
        end
        check("fill_cnt", 64'(pend_cnt), 64'h0);

        // Reserve r5, then release it through a bypassed write.
        res_en = 1'b1;
        res_n  = 5'd5;
        rn     = {5'd2, 5'd5};
        #1;
        check("res5_same_cycle_ready", 64'(rd_ready), 64'h3);
        tick();
        res_en = 1'b0;
        check("res5_ready",  64'(rd_ready),    64'h2);
        check("res5_cnt",    64'(pend_cnt),    64'h1);
        check("res5_any",    64'(any_pending), 64'h1);
        check("res5_rd",     64'(rd),          {32'd4, 32'd25});
        w  = 1'b1;
        wn = 5'd5;
        wd = 32'h0000_ABCD;
        #1;
        check("byp5_rd",     64'(rd),          {32'd4, 32'h0000_ABCD});
        check("byp5_ready",  64'(rd_ready),    64'h3);
        check("byp5_cnt",    64'(pend_cnt),    64'h1);
        tick();
        w = 1'b0;
        check("wb5_cnt",     64'(pend_cnt),    64'h0);
        check("wb5_any",     64'(any_pending), 64'h0);
        check("wb5_ready",   64'(rd_ready),    64'h3);
        check("wb5_rd",      64'(rd),          {32'd4, 32'h0000_ABCD});

        // Write and reserve r7 in the same cycle while r7 is already pending.
        res_en = 1'b1;
        res_n  = 5'd7;
        tick();
        check("res7_cnt", 64'(pend_cnt), 64'h1);
        w      = 1'b1;
        wn     = 5'd7;
        wd     = 32'h11;
        tick();
        w      = 1'b0;
        res_en = 1'b0;
        rn     = {5'd9, 5'd7};
        #1;
        check("wr_res7_rd",    64'(rd),       {32'd81, 32'h11});
        check("wr_res7_ready", 64'(rd_ready), 64'h2);
        check("wr_res7_cnt",   64'(pend_cnt), 64'h1);

        // Write r7 and reserve r9 together: one cleared, one set.
        w      = 1'b1;
        wn     = 5'd7;
        wd     = 32'h22;
        res_en = 1'b1;
        res_n  = 5'd9;
        tick();
        w      = 1'b0;
        res_en = 1'b0;
        check("swap_cnt",   64'(pend_cnt), 64'h1);
        check("swap_ready", 64'(rd_ready), 64'h1);
        check("swap_rd",    64'(rd),       {32'd81, 32'h22});

        // R0 ignores both write and reserve.
        rn     = {5'd9, 5'd0};
        w      = 1'b1;
        wn     = 5'd0;
        wd     = 32'hFFFF_FFFF;
        res_en = 1'b1;
        res_n  = 5'd0;
        #1;
        check("r0_same_rd",    64'(rd),       {32'd81, 32'h0});
        check("r0_same_ready", 64'(rd_ready), 64'h1);
        tick();
        w      = 1'b0;
        res_en = 1'b0;
        check("r0_rd",    64'(rd),       {32'd81, 32'h0});
        check("r0_ready", 64'(rd_ready), 64'h1);
        check("r0_cnt",   64'(pend_cnt), 64'h1);

        // Non-bypassed write of a pending register clears it; r9 had been pending.
        w  = 1'b1;
        wn = 5'd9;
        wd = 32'h99;
        tick();
        w = 1'b0;
        check("wb9_cnt", 64'(pend_cnt), 64'h0);
        check("wb9_rd",  64'(rd),       {32'h99, 32'h0});

        // Fill the scoreboard: r1..r31.
        for (int i = 1; i < 32; i++) begin
            res_en = 1'b1;
            res_n  = 5'(i);
            tick();
        end
        res_en = 1'b0;
        rn     = {5'd12, 5'd0};
        #1;
        check("full_cnt",   64'(pend_cnt),    64'd31);
        check("full_any",   64'(any_pending), 64'h1);
        check("full_ready", 64'(rd_ready),    64'h1);
        res_en = 1'b1;
        res_n  = 5'd5;
        tick();
        res_en = 1'b0;
        check("full_rereserve_cnt", 64'(pend_cnt), 64'd31);

        // Mid-cycle reset.
        #2;
        reset = 1'b1;
        #1;
        check("midrst_cnt",   64'(pend_cnt),    64'h0);
        check("midrst_any",   64'(any_pending), 64'h0);
        check("midrst_rd",    64'(rd),          64'h0);
        check("midrst_ready", 64'(rd_ready),    64'h3);
        @(negedge clk);
        reset = 1'b0;
        rn    = {5'd12, 5'd31};
        #1;
        check("postrst_rd",    64'(rd),       64'h0);
        check("postrst_ready", 64'(rd_ready), 64'h3);
        check("postrst_cnt",   64'(pend_cnt), 64'h0);

        // Narrow instance without bypass: same-cycle reads see the old value.
        rn2 = {4{3'd3}};
        w2  = 1'b1;
        wn2 = 3'd3;
        wd2 = 16'h1234;
        #1;
        check("nobyp_same_rd",    64'(rd2),       64'h0);
        check("nobyp_same_ready", 64'(rd_ready2), 64'hF);
        tick();
        w2 = 1'b0;
        check("nobyp_next_rd",    64'(rd2),       64'h1234_1234_1234_1234);
        check("nobyp_next_ready", 64'(rd_ready2), 64'hF);
        check("nobyp_cnt",        64'(pend_cnt2), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Parametrised successor to the team's 2-read/1-write 32x32 register file.
- Configurable data width, depth and read-port count.
- Adds an asynchronous clear, optional hardwired-zero R0 and optional write-to-read bypass.
- Adds a per-register pending scoreboard, so a pipelined datapath can reserve a destination at issue and stall readers until writeback.
- Sits between decode/issue (reserve, read) and writeback (write) in the CPU datapath.

Parameters:
- W, 32, data width in bits.
- AW, 5, register address width; depth N = 2**AW.
- NREAD, 2, number of read ports (1..4).
- ZERO_R0, 1, when 1 register 0 always reads 0, never becomes pending, and ignores writes.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- rn  input  NREAD*AW  read addresses; port k uses bits [k*AW +: AW].
- rd  output  NREAD*W  read data; port k uses bits [k*W +: W].
- rd_ready  output  NREAD  port k ready: the register is not pending, or it is being bypassed.
- wn  input  AW  write address.
- wd  input  W  write data.
- w  input  1  write enable.
- res_en  input  1  reserve request.
- res_n  input  AW  register to mark pending.
- pend_cnt  output  AW+1  number of registers currently pending.
- any_pending  output  1  pend_cnt != 0.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - all N registers go to 0;
  - all pending bits clear;
  - pend_cnt = 0, any_pending = 0.
  - While reset is high, rd = 0 and rd_ready = all ones.
- Reads are combinational, zero latency.
  - rd[k] = reg[rn[k]].
  - With BYPASS=1, when w && wn==rn[k] (and not suppressed by ZERO_R0), rd[k] = wd.
- rd_ready[k] = !pend[rn[k]] || (BYPASS && w && wn==rn[k]).
  - R0 is always ready when ZERO_R0=1.
- Write: on a rising clk with w=1, reg[wn] <= wd and pend[wn] <= 0.
  - With ZERO_R0=1 and wn==0, the write is discarded.
  - A write to a non-pending register is legal and leaves the scoreboard unchanged.
- Reserve: on a rising clk with res_en=1, pend[res_n] <= 1.
  - With ZERO_R0=1 and res_n==0, the reserve is ignored.
  - Reserving an already-pending register leaves it pending; the count is unchanged.
- Simultaneous write and reserve, same register, same cycle:
  - the data is written and the register stays pending (reserve wins, since it marks a newer producer);
  - pend_cnt is unchanged if the register was pending, +1 if it was not.
- Simultaneous write and reserve, different registers: both take effect; pend_cnt changes by (+1 if the reserve set a new bit) + (−1 if the write cleared a set bit).
- A reserve or write takes effect on rd_ready in the next cycle only; same-cycle visibility exists only through the data bypass.
- pend_cnt is a registered counter kept consistent with the pending bits.
  - Maximum is N−1 with ZERO_R0=1, N otherwise; it never wraps.
- Arithmetic: none on data; pend_cnt is AW+1 bits so it can hold N.
- Timing: 1-cycle write latency (or 0 with bypass), 1-cycle scoreboard latency, no backpressure.

Decomposition:
- Package rf_pkg:
  - default W, AW, NREAD constants;
  - function for the port-k address/data slice offsets.
- Sub-module rf_pending_ctl: holds the pending vector and pend_cnt; inputs are the write/reserve events after R0 filtering; outputs are the pending vector and the count.
- Top rf_scoreboard: holds the storage array, the read muxes and the bypass logic, and instantiates rf_pending_ctl.

Test Plan:
- Reset, then for i=0..31 write wd=i*i to wn=i; read random rn pairs.
  - Expect rd=rn*rn, except rn=0 gives 0 (ZERO_R0=1).
  - Expect rd_ready=11 and pend_cnt=0.
- Reserve r5; next cycle read rn0=5.
  - Expect rd_ready[0]=0, pend_cnt=1.
  - Then write wd=0xABCD to r5: same cycle rd=0xABCD and rd_ready[0]=1 (bypass).
  - Next cycle: pending clear, pend_cnt=0.
- Same cycle: write r7=0x11 and reserve r7, with r7 previously pending.
  - Expect reg[7]=0x11 visible, rd_ready=0 for r7, pend_cnt unchanged.
- Write r0=0xFFFF_FFFF and reserve r0.
  - Expect rd for rn=0 = 0, rd_ready=1, pend_cnt unchanged.
- Reserve r1..r31 in successive cycles.
  - Expect pend_cnt=31, any_pending=1.
  - Assert reset mid-cycle (between edges): all outputs clear immediately, pend_cnt=0, rd=0.
- W=16, AW=3, NREAD=4, BYPASS=0: write r3=0x1234 while all four ports read r3.
  - Same cycle: rd shows the old value 0 on all ports.
  - Next cycle: rd=0x1234 on all ports.
